// File: rtl/trdb_itype_sequencer_if.sv
// Core-retire and emitter-side signal bundle for the itype sequencer.
// slave = sequencer, master = core/emitter side.
interface trdb_itype_sequencer_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
);
  logic             trace_enable_i;
  logic             inst_valid_i;
  logic             inst_ready_o;
  logic [XLEN-1:0]  inst_data_i;
  logic [XLEN-1:0]  iaddr_i;
  logic             compressed_i;
  logic             exception_i;
  logic [XLEN-1:0]  tc_iaddr_o;
  logic             tc_compressed_o;
  logic [XLEN-1:0]  nc_inst_data_o;
  logic [XLEN-1:0]  nc_iaddr_o;
  logic             nc_exception_o;
  logic             pair_valid_o;
  logic             nc_valid_o;
  logic             last_o;
  logic             first_o;
  logic             pair_ready_i;
  logic [CNT_W-1:0] irCount_o;

  modport slave (
    input  trace_enable_i, inst_valid_i, inst_data_i, iaddr_i, compressed_i,
           exception_i, pair_ready_i,
    output inst_ready_o, tc_iaddr_o, tc_compressed_o, nc_inst_data_o,
           nc_iaddr_o, nc_exception_o, pair_valid_o, nc_valid_o, last_o,
           first_o, irCount_o
  );

  modport master (
    output trace_enable_i, inst_valid_i, inst_data_i, iaddr_i, compressed_i,
           exception_i, pair_ready_i,
    input  inst_ready_o, tc_iaddr_o, tc_compressed_o, nc_inst_data_o,
           nc_iaddr_o, nc_exception_o, pair_valid_o, nc_valid_o, last_o,
           first_o, irCount_o
  );
endinterface

// File: rtl/trdb_itype_sequencer.sv
// Shifts retired instructions into the tc/nc stage pair; stage outputs are registered (1-cycle).
// In RUN the core is accepted only as the emitter consumes the held pair; IDLE/DRAIN refuse input.
module trdb_itype_sequencer #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  trdb_itype_sequencer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, FILL, RUN, DRAIN} state_e;

  state_e           state_q, state_d;
  logic [XLEN-1:0]  tc_iaddr_q, tc_iaddr_d;
  logic             tc_c_q, tc_c_d;
  logic [XLEN-1:0]  nc_data_q, nc_data_d;
  logic [XLEN-1:0]  nc_iaddr_q, nc_iaddr_d;
  logic             nc_c_q, nc_c_d;
  logic             nc_exc_q, nc_exc_d;
  logic             tc_valid_q, tc_valid_d;
  logic             nc_valid_q, nc_valid_d;
  logic             first_q, first_d;
  logic             last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic inst_ready;
  logic fire;
  logic do_shift;
  logic do_clear;

  always_comb begin
    inst_ready = 1'b0;
    unique case (state_q)
      FILL:    inst_ready = bus.trace_enable_i;
      RUN:     inst_ready = bus.trace_enable_i & bus.pair_ready_i;
      default: inst_ready = 1'b0;
    endcase
  end

  assign fire = bus.inst_valid_i & inst_ready;

  always_comb begin
    state_d    = state_q;
    tc_iaddr_d = tc_iaddr_q;
    tc_c_d     = tc_c_q;
    nc_data_d  = nc_data_q;
    nc_iaddr_d = nc_iaddr_q;
    nc_c_d     = nc_c_q;
    nc_exc_d   = nc_exc_q;
    tc_valid_d = tc_valid_q;
    nc_valid_d = nc_valid_q;
    first_d    = first_q;
    last_d     = last_q;
    cnt_d      = cnt_q;
    do_shift   = 1'b0;
    do_clear   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.trace_enable_i) begin
          state_d = FILL;
          cnt_d   = '0;
        end
      end
      FILL: begin
        if (fire) begin
          if (nc_valid_q) begin
            state_d = RUN;
            first_d = 1'b1;
          end
        end else if (!bus.trace_enable_i) begin
          if (nc_valid_q) do_shift = 1'b1;
          else            state_d  = IDLE;
        end
      end
      RUN: begin
        if (fire) begin
          first_d = 1'b0;
        end else if (!bus.trace_enable_i && (!tc_valid_q || bus.pair_ready_i)) begin
          do_shift = 1'b1;
        end else if (bus.pair_ready_i && tc_valid_q) begin
          tc_valid_d = 1'b0;
          first_d    = 1'b0;
        end
      end
      DRAIN: begin
        if (bus.pair_ready_i) do_clear = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    if (fire) begin
      tc_iaddr_d = nc_iaddr_q;
      tc_c_d     = nc_c_q;
      tc_valid_d = nc_valid_q;
      nc_data_d  = bus.inst_data_i;
      nc_iaddr_d = bus.iaddr_i;
      nc_c_d     = bus.compressed_i;
      nc_exc_d   = bus.exception_i;
      nc_valid_d = 1'b1;
      if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + 1'b1;
    end

    // Final pair: the held nc becomes tc with no successor, so the detector sees last.
    if (do_shift) begin
      tc_iaddr_d = nc_iaddr_q;
      tc_c_d     = nc_c_q;
      tc_valid_d = 1'b1;
      nc_valid_d = 1'b0;
      last_d     = 1'b1;
      first_d    = 1'b0;
      state_d    = DRAIN;
    end

    if (do_clear) begin
      tc_iaddr_d = '0;
      tc_c_d     = 1'b0;
      nc_data_d  = '0;
      nc_iaddr_d = '0;
      nc_c_d     = 1'b0;
      nc_exc_d   = 1'b0;
      tc_valid_d = 1'b0;
      nc_valid_d = 1'b0;
      first_d    = 1'b0;
      last_d     = 1'b0;
      state_d    = IDLE;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      tc_iaddr_q <= '0;
      tc_c_q     <= 1'b0;
      nc_data_q  <= '0;
      nc_iaddr_q <= '0;
      nc_c_q     <= 1'b0;
      nc_exc_q   <= 1'b0;
      tc_valid_q <= 1'b0;
      nc_valid_q <= 1'b0;
      first_q    <= 1'b0;
      last_q     <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      tc_iaddr_q <= tc_iaddr_d;
      tc_c_q     <= tc_c_d;
      nc_data_q  <= nc_data_d;
      nc_iaddr_q <= nc_iaddr_d;
      nc_c_q     <= nc_c_d;
      nc_exc_q   <= nc_exc_d;
      tc_valid_q <= tc_valid_d;
      nc_valid_q <= nc_valid_d;
      first_q    <= first_d;
      last_q     <= last_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus.inst_ready_o    = inst_ready;
  assign bus.tc_iaddr_o      = tc_iaddr_q;
  assign bus.tc_compressed_o = tc_c_q;
  assign bus.nc_inst_data_o  = nc_data_q;
  assign bus.nc_iaddr_o      = nc_iaddr_q;
  assign bus.nc_exception_o  = nc_exc_q;
  assign bus.pair_valid_o    = tc_valid_q;
  assign bus.nc_valid_o      = nc_valid_q;
  assign bus.last_o          = last_q;
  assign bus.first_o         = first_q;
  assign bus.irCount_o       = cnt_q;

endmodule

// File: tb/tb_trdb_itype_sequencer.sv
// Directed bench for trdb_itype_sequencer: per-cycle vector table plus stream,
// drain and saturation/async-reset sequences.
module tb_trdb_itype_sequencer;

  localparam int XLEN  = 32;
  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  trdb_itype_sequencer_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus();

  trdb_itype_sequencer #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  // inb = {en, vld, c, exc, prdy}; outb = {rdy, pv, ncv, first, last, tc_c, nc_exc}
  typedef struct packed {
    logic [4:0]  inb;
    logic [31:0] addr;
    logic [6:0]  outb;
    logic [31:0] tca;
    logic [31:0] nca;
    logic [3:0]  cnt;
  } vec_t;

  vec_t tbl [28];
  int compared = 0;
  int failed   = 0;

  function automatic vec_t mk(input logic [4:0] inb, input logic [31:0] addr,
                              input logic [6:0] outb, input logic [31:0] tca,
                              input logic [31:0] nca, input logic [3:0] cnt);
    vec_t v;
    v.inb = inb; v.addr = addr; v.outb = outb; v.tca = tca; v.nca = nca; v.cnt = cnt;
    return v;
  endfunction

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return 32'hA500_0000 | a;
  endfunction

  function automatic logic [127:0] outs();
    return {21'b0, bus.inst_ready_o, bus.pair_valid_o, bus.nc_valid_o, bus.first_o,
            bus.last_o, bus.tc_compressed_o, bus.nc_exception_o, bus.tc_iaddr_o,
            bus.nc_iaddr_o, bus.nc_inst_data_o, bus.irCount_o};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    compared++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic en, input logic vld, input logic [31:0] addr,
                       input logic c, input logic exc, input logic prdy);
    bus.trace_enable_i = en;
    bus.inst_valid_i   = vld;
    bus.iaddr_i        = addr;
    bus.inst_data_i    = data_of(addr);
    bus.compressed_i   = c;
    bus.exception_i    = exc;
    bus.pair_ready_i   = prdy;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ncd;
    int idx, n, low, stall_left, fires, cyc;
    logic prdy, fire;

    tbl[0]  = mk(5'b10000, 32'h000, 7'b0000000, 32'h000, 32'h000, 4'd0);
    tbl[1]  = mk(5'b11001, 32'h080, 7'b1000000, 32'h000, 32'h000, 4'd0);
    tbl[2]  = mk(5'b11101, 32'h084, 7'b1010000, 32'h000, 32'h080, 4'd1);
    tbl[3]  = mk(5'b10000, 32'h000, 7'b0111000, 32'h080, 32'h084, 4'd2);
    tbl[4]  = mk(5'b11001, 32'h088, 7'b1111000, 32'h080, 32'h084, 4'd2);
    tbl[5]  = mk(5'b10001, 32'h000, 7'b1110010, 32'h084, 32'h088, 4'd3);
    tbl[6]  = mk(5'b10000, 32'h000, 7'b0010010, 32'h084, 32'h088, 4'd3);
    tbl[7]  = mk(5'b11001, 32'h100, 7'b1010010, 32'h084, 32'h088, 4'd3);
    tbl[8]  = mk(5'b01000, 32'h104, 7'b0110000, 32'h088, 32'h100, 4'd4);
    tbl[9]  = mk(5'b01001, 32'h104, 7'b0110000, 32'h088, 32'h100, 4'd4);
    tbl[10] = mk(5'b11000, 32'h104, 7'b0100100, 32'h100, 32'h100, 4'd4);
    tbl[11] = mk(5'b10001, 32'h000, 7'b0100100, 32'h100, 32'h100, 4'd4);
    tbl[12] = mk(5'b00000, 32'h000, 7'b0000000, 32'h000, 32'h000, 4'd4);
    tbl[13] = mk(5'b10000, 32'h000, 7'b0000000, 32'h000, 32'h000, 4'd4);
    tbl[14] = mk(5'b11010, 32'h200, 7'b1000000, 32'h000, 32'h000, 4'd0);
    tbl[15] = mk(5'b11000, 32'h204, 7'b1010001, 32'h000, 32'h200, 4'd1);
    tbl[16] = mk(5'b10000, 32'h000, 7'b0111000, 32'h200, 32'h204, 4'd2);
    tbl[17] = mk(5'b00001, 32'h000, 7'b0111000, 32'h200, 32'h204, 4'd2);
    tbl[18] = mk(5'b00001, 32'h000, 7'b0100100, 32'h204, 32'h204, 4'd2);
    tbl[19] = mk(5'b10000, 32'h000, 7'b0000000, 32'h000, 32'h000, 4'd2);
    tbl[20] = mk(5'b11000, 32'h300, 7'b1000000, 32'h000, 32'h000, 4'd0);
    tbl[21] = mk(5'b01000, 32'h304, 7'b0010000, 32'h000, 32'h300, 4'd1);
    tbl[22] = mk(5'b00000, 32'h000, 7'b0100100, 32'h300, 32'h300, 4'd1);
    tbl[23] = mk(5'b00001, 32'h000, 7'b0100100, 32'h300, 32'h300, 4'd1);
    tbl[24] = mk(5'b00000, 32'h000, 7'b0000000, 32'h000, 32'h000, 4'd1);
    tbl[25] = mk(5'b10000, 32'h000, 7'b0000000, 32'h000, 32'h000, 4'd1);
    tbl[26] = mk(5'b01000, 32'h400, 7'b0000000, 32'h000, 32'h000, 4'd0);
    tbl[27] = mk(5'b00000, 32'h000, 7'b0000000, 32'h000, 32'h000, 4'd0);

    // Reset, then 10 idle cycles with tracing off
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1 chk($sformatf("reset_idle[%0d]", i), outs(), 128'b0);
    end

    // Per-cycle vectors: start-up, stall/consume, disable mid-stream, exception, short traces
    for (int i = 0; i < 28; i++) begin
      @(negedge clk);
      drive(tbl[i].inb[4], tbl[i].inb[3], tbl[i].addr, tbl[i].inb[2], tbl[i].inb[1], tbl[i].inb[0]);
      ncd = (tbl[i].nca == 32'h0) ? 32'h0 : data_of(tbl[i].nca);
      #1 chk($sformatf("vec[%0d]", i), outs(),
             {21'b0, tbl[i].outb, tbl[i].tca, tbl[i].nca, ncd, tbl[i].cnt});
      @(posedge clk);
    end

    // 100-instruction stream with a 3-cycle emitter stall at instruction 50
    @(negedge clk);
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    @(posedge clk);
    idx = 0; n = 0; low = 0; stall_left = 3; cyc = 0;
    while (!(idx == 100 && n == 99) && cyc < 400) begin
      @(negedge clk);
      prdy = !(idx >= 50 && stall_left > 0);
      drive(1'b1, idx < 100, 32'h1000 + 32'(idx * 4), 1'b0, 1'b0, prdy);
      #1;
      if (idx >= 2 && idx < 100 && !bus.inst_ready_o) low++;
      if (bus.pair_valid_o && prdy) begin
        chk($sformatf("stream_pair[%0d]", n), {96'b0, bus.tc_iaddr_o}, {96'b0, 32'h1000 + 32'(n * 4)});
        n++;
      end
      fire = bus.inst_valid_i & bus.inst_ready_o;
      if (!prdy) stall_left--;
      @(posedge clk);
      if (fire) idx++;
      cyc++;
    end
    chk("stream_done", {64'b0, 32'(idx), 32'(n)}, {64'b0, 32'd100, 32'd99});
    chk("stream_ready_low", 128'(low), 128'd3);
    chk("stream_cnt_sat", {124'b0, bus.irCount_o}, 128'd15);

    // Disable after the stream: final drain pair carries the last instruction
    @(negedge clk);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    #1 chk("drain_entry_rdy", {127'b0, bus.inst_ready_o}, 128'b0);
    @(posedge clk);
    @(negedge clk);
    #1 chk("drain_pair", {91'b0, bus.pair_valid_o, bus.nc_valid_o, bus.last_o, bus.first_o,
                          bus.inst_ready_o, bus.tc_iaddr_o},
           {91'b0, 5'b10100, 32'h1000 + 32'd396});
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    @(posedge clk);
    @(negedge clk);
    #1 chk("drain_to_idle", {124'b0, bus.pair_valid_o, bus.nc_valid_o, bus.last_o, bus.inst_ready_o}, 128'b0);

    // 20 fires into a 4-bit counter, then async reset mid-pair
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    @(posedge clk);
    fires = 0; cyc = 0;
    while (fires < 20 && cyc < 100) begin
      @(negedge clk);
      drive(1'b1, 1'b1, 32'h2000 + 32'(fires * 4), 1'b0, 1'b0, 1'b1);
      #1 if (bus.inst_ready_o) fires++;
      @(posedge clk);
      cyc++;
    end
    chk("sat_fires", 128'(fires), 128'd20);
    @(negedge clk);
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    #1 chk("sat_hold", {122'b0, bus.irCount_o, bus.pair_valid_o, bus.inst_ready_o},
           {122'b0, 4'd15, 1'b1, 1'b1});
    #2 rst_n = 1'b0;
    #1 chk("async_reset", outs(), 128'b0);
    @(negedge clk);
    #1 chk("reset_held", outs(), 128'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
